mem_handshake_ctrl: RTL and testbench

//  Sequences every CPU memory transaction onto the shared readM/writeM/address/data bus.

---
 rtl/mem_handshake_ctrl_pkg.sv | 20 ++
 rtl/mem_timeout_counter.sv | 37 +++
 rtl/mem_handshake_ctrl.sv | 170 +++++++++++++++++
 tb/tb_mem_handshake_ctrl.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_handshake_ctrl_pkg.sv
// Shared encodings for the CPU memory handshake controller: FSM states,
// transaction kinds and the default bus width.
package mem_handshake_ctrl_pkg;

   localparam int WORD_SIZE_DEF = 16;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RD_WAIT = 2'd1,
      WR_WAIT = 2'd2,
      DONE    = 2'd3
   } state_e;

   typedef enum logic [1:0] {
      KIND_FETCH = 2'd0,
      KIND_LOAD  = 2'd1,
      KIND_STORE = 2'd2
   } kind_e;

endpackage

// File: rtl/mem_timeout_counter.sv
// Wait-state cycle counter; expire is high on the terminal wait cycle (count == TIMEOUT_CYCLES-1).
// Cleared on transaction accept, advances only while enable is high, holds at the terminal count.
module mem_timeout_counter #(
   parameter int TIMEOUT_CYCLES = 15
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clear,
   input  logic enable,
   output logic expire
);

   localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (enable && (cnt_q != LAST)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expire = enable && (cnt_q == LAST);

endmodule

// File: rtl/mem_handshake_ctrl.sv
// Serialises one fetch / load / store at a time onto the shared memory bus; strobe one cycle after accept,
// done/err pulse one cycle after response or timeout, then one DONE cycle; requests are ignored while busy.
module mem_handshake_ctrl
   import mem_handshake_ctrl_pkg::*;
#(
   parameter int WORD_SIZE      = WORD_SIZE_DEF,
   parameter int TIMEOUT_CYCLES = 15
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 fetch_req,
   input  logic [WORD_SIZE-1:0] fetch_addr,
   input  logic                 mem_read,
   input  logic                 mem_write,
   input  logic [WORD_SIZE-1:0] mem_address,
   input  logic [WORD_SIZE-1:0] mem_data,
   output logic [WORD_SIZE-1:0] instr,
   output logic                 fetch_done,
   output logic [WORD_SIZE-1:0] rdata,
   output logic                 data_done,
   output logic                 timeout_err,
   output logic                 busy,
   output logic                 readM,
   output logic                 writeM,
   output logic [WORD_SIZE-1:0] address,
   inout  wire  [WORD_SIZE-1:0] data,
   input  logic                 inputReady,
   input  logic                 ackOutput
);

   state_e               state_q, state_d;
   kind_e                kind_q, kind_d;
   logic [WORD_SIZE-1:0] address_q, address_d;
   logic [WORD_SIZE-1:0] wdata_q, wdata_d;
   logic [WORD_SIZE-1:0] instr_q, instr_d;
   logic [WORD_SIZE-1:0] rdata_q, rdata_d;
   logic                 fetch_done_q, fetch_done_d;
   logic                 data_done_q, data_done_d;
   logic                 timeout_err_q, timeout_err_d;
   logic                 readM_q, readM_d;
   logic                 writeM_q, writeM_d;
   logic                 busy_q, busy_d;
   logic                 tmr_clear, tmr_enable, tmr_expire;

   mem_timeout_counter #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk     (clk),
      .reset_n (reset_n),
      .clear   (tmr_clear),
      .enable  (tmr_enable),
      .expire  (tmr_expire)
   );

   assign tmr_enable = (state_q == RD_WAIT) || (state_q == WR_WAIT);

   always_comb begin
      state_d       = state_q;
      kind_d        = kind_q;
      address_d     = address_q;
      wdata_d       = wdata_q;
      instr_d       = instr_q;
      rdata_d       = rdata_q;
      fetch_done_d  = 1'b0;
      data_done_d   = 1'b0;
      timeout_err_d = 1'b0;
      tmr_clear     = 1'b0;

      case (state_q)
         IDLE: begin
            // read outranks write, so an illegal read+write request behaves as a read
            if (mem_read) begin
               kind_d    = KIND_LOAD;
               address_d = mem_address;
               tmr_clear = 1'b1;
               state_d   = RD_WAIT;
            end else if (mem_write) begin
               kind_d    = KIND_STORE;
               address_d = mem_address;
               wdata_d   = mem_data;
               tmr_clear = 1'b1;
               state_d   = WR_WAIT;
            end else if (fetch_req) begin
               kind_d    = KIND_FETCH;
               address_d = fetch_addr;
               tmr_clear = 1'b1;
               state_d   = RD_WAIT;
            end
         end
         RD_WAIT: begin
            if (inputReady) begin
               if (kind_q == KIND_FETCH) begin
                  instr_d      = data;
                  fetch_done_d = 1'b1;
               end else begin
                  rdata_d     = data;
                  data_done_d = 1'b1;
               end
               state_d = DONE;
            end else if (tmr_expire) begin
               timeout_err_d = 1'b1;
               state_d       = DONE;
            end
         end
         WR_WAIT: begin
            if (ackOutput) begin
               data_done_d = 1'b1;
               state_d     = DONE;
            end else if (tmr_expire) begin
               timeout_err_d = 1'b1;
               state_d       = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      readM_d  = (state_d == RD_WAIT);
      writeM_d = (state_d == WR_WAIT);
      busy_d   = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset_n) begin
         state_q       <= IDLE;
         kind_q        <= KIND_FETCH;
         address_q     <= '0;
         wdata_q       <= '0;
         instr_q       <= '0;
         rdata_q       <= '0;
         fetch_done_q  <= 1'b0;
         data_done_q   <= 1'b0;
         timeout_err_q <= 1'b0;
         readM_q       <= 1'b0;
         writeM_q      <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         kind_q        <= kind_d;
         address_q     <= address_d;
         wdata_q       <= wdata_d;
         instr_q       <= instr_d;
         rdata_q       <= rdata_d;
         fetch_done_q  <= fetch_done_d;
         data_done_q   <= data_done_d;
         timeout_err_q <= timeout_err_d;
         readM_q       <= readM_d;
         writeM_q      <= writeM_d;
         busy_q        <= busy_d;
      end
   end

   assign instr       = instr_q;
   assign rdata       = rdata_q;
   assign fetch_done  = fetch_done_q;
   assign data_done   = data_done_q;
   assign timeout_err = timeout_err_q;
   assign readM       = readM_q;
   assign writeM      = writeM_q;
   assign busy        = busy_q;
   assign address     = address_q;

   // only bus driver in the design; released in every state but WR_WAIT
   assign data = (state_q == WR_WAIT) ? wdata_q : {WORD_SIZE{1'bz}};

endmodule

// File: tb/tb_mem_handshake_ctrl.sv
// Directed bench for mem_handshake_ctrl: fetch, store, priority, timeout, reset abort, spurious responses.
// Inputs change 1ns after posedge; outputs are sampled there too, away from the sampling edge.
module tb_mem_handshake_ctrl;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        fetch_req;
   logic [15:0] fetch_addr;
   logic        mem_read;
   logic        mem_write;
   logic [15:0] mem_address;
   logic [15:0] mem_data;
   logic [15:0] instr;
   logic        fetch_done;
   logic [15:0] rdata;
   logic        data_done;
   logic        timeout_err;
   logic        busy;
   logic        readM;
   logic        writeM;
   logic [15:0] address;
   wire  [15:0] data;
   logic        inputReady;
   logic        ackOutput;

   logic        tb_drv;
   logic [15:0] tb_dat;

   int n_chk = 0;
   int n_err = 0;
   int rd_cnt;

   assign data = tb_drv ? tb_dat : 16'hzzzz;

   always #5 clk = ~clk;

   mem_handshake_ctrl #(
      .WORD_SIZE      (16),
      .TIMEOUT_CYCLES (15)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .fetch_req   (fetch_req),
      .fetch_addr  (fetch_addr),
      .mem_read    (mem_read),
      .mem_write   (mem_write),
      .mem_address (mem_address),
      .mem_data    (mem_data),
      .instr       (instr),
      .fetch_done  (fetch_done),
      .rdata       (rdata),
      .data_done   (data_done),
      .timeout_err (timeout_err),
      .busy        (busy),
      .readM       (readM),
      .writeM      (writeM),
      .address     (address),
      .data        (data),
      .inputReady  (inputReady),
      .ackOutput   (ackOutput)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // a released bus must read back exactly what the bench drives onto it
   task automatic chk_z(input string tag);
      tb_drv = 1'b1;
      tb_dat = 16'h0000;
      #1;
      check(tag, {16'h0, data}, 32'h0);
      tb_drv = 1'b0;
   endtask

   task automatic respond_rd(input logic [15:0] d);
      inputReady = 1'b1;
      tb_drv     = 1'b1;
      tb_dat     = d;
   endtask

   task automatic release_rd();
      inputReady = 1'b0;
      tb_drv     = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n = 1'b1; fetch_req = 1'b0; fetch_addr = '0; mem_read = 1'b0; mem_write = 1'b0;
      mem_address = '0; mem_data = '0; inputReady = 1'b0; ackOutput = 1'b0;
      tb_drv = 1'b0; tb_dat = '0;
      tick(); tick();
      check("rst_readM", readM, 0);
      check("rst_writeM", writeM, 0);
      check("rst_address", address, 0);
      check("rst_instr", instr, 0);
      check("rst_rdata", rdata, 0);
      check("rst_busy", busy, 0);
      check("rst_pulses", {fetch_done, data_done, timeout_err}, 0);
      chk_z("rst_data_z");
      reset_n = 1'b0;
      tick();

      // fetch from 0x0004, response two cycles into RD_WAIT
      fetch_req = 1'b1; fetch_addr = 16'h0004;
      tick();
      check("f_readM", readM, 1);
      check("f_address", address, 16'h0004);
      check("f_busy", busy, 1);
      tick();
      check("f_readM2", readM, 1);
      respond_rd(16'h6A01);
      tick();
      release_rd();
      check("f_done", fetch_done, 1);
      check("f_instr", instr, 16'h6A01);
      check("f_readM_off", readM, 0);
      tick();
      check("f_done_single", fetch_done, 0);
      check("f_no_refetch", readM, 0);
      check("f_idle", busy, 0);
      fetch_req = 1'b0;
      tick();
      check("f_still_idle", readM, 0);

      // store 0xBEEF to 0x00C0, ack on third WR_WAIT cycle, request changes ignored
      chk_z("s_data_z_before");
      mem_write = 1'b1; mem_address = 16'h00C0; mem_data = 16'hBEEF;
      tick();
      mem_address = 16'h00FF; mem_data = 16'h1234;
      check("s_writeM", writeM, 1);
      check("s_readM", readM, 0);
      check("s_address", address, 16'h00C0);
      check("s_data", data, 16'hBEEF);
      tick(); tick();
      check("s_data_held", data, 16'hBEEF);
      check("s_address_held", address, 16'h00C0);
      ackOutput = 1'b1;
      tick();
      ackOutput = 1'b0; mem_write = 1'b0;
      check("s_done", data_done, 1);
      check("s_writeM_off", writeM, 0);
      chk_z("s_data_z_after");
      tick();
      check("s_done_single", data_done, 0);
      check("s_idle", busy, 0);

      // load and fetch raised together: load first, fetch accepted 4 edges after load accept
      fetch_req = 1'b1; fetch_addr = 16'h0010; mem_read = 1'b1; mem_address = 16'h0200;
      tick();
      check("p_load_addr", address, 16'h0200);
      check("p_readM", readM, 1);
      tick();
      respond_rd(16'h1357);
      tick();
      release_rd();
      mem_read = 1'b0;
      check("p_data_done", data_done, 1);
      check("p_no_fetch_done", fetch_done, 0);
      check("p_rdata", rdata, 16'h1357);
      check("p_instr_kept", instr, 16'h6A01);
      tick();
      check("p_gap_idle", readM, 0);
      tick();
      check("p_fetch_readM", readM, 1);
      check("p_fetch_addr", address, 16'h0010);
      respond_rd(16'h2468);
      tick();
      release_rd();
      fetch_req = 1'b0;
      check("p_fetch_done", fetch_done, 1);
      check("p_instr", instr, 16'h2468);
      check("p_rdata_kept", rdata, 16'h1357);
      tick();

      // fetch with no response: readM for exactly 15 cycles then timeout_err
      fetch_req = 1'b1; fetch_addr = 16'h0020;
      tick();
      rd_cnt = 0;
      for (int i = 0; i < 15; i++) begin
         if (readM) rd_cnt++;
         tick();
      end
      fetch_req = 1'b0;
      check("t_readM_cycles", rd_cnt, 15);
      check("t_readM_off", readM, 0);
      check("t_err", timeout_err, 1);
      check("t_no_done", {fetch_done, data_done}, 0);
      check("t_instr_kept", instr, 16'h2468);
      tick();
      check("t_err_single", timeout_err, 0);
      check("t_idle", busy, 0);

      // response on the terminal wait cycle beats the timeout
      fetch_req = 1'b1; fetch_addr = 16'h0030;
      tick();
      for (int i = 0; i < 14; i++) tick();
      check("t15_readM", readM, 1);
      respond_rd(16'h0F0F);
      tick();
      release_rd();
      fetch_req = 1'b0;
      check("t15_done", fetch_done, 1);
      check("t15_no_err", timeout_err, 0);
      check("t15_instr", instr, 16'h0F0F);
      tick();

      // reset pulse in the middle of WR_WAIT
      mem_write = 1'b1; mem_address = 16'h0044; mem_data = 16'hCAFE;
      tick();
      check("r_writeM", writeM, 1);
      tick();
      reset_n = 1'b1;
      tick();
      reset_n = 1'b0; mem_write = 1'b0;
      check("r_writeM_off", writeM, 0);
      check("r_busy", busy, 0);
      check("r_no_pulse", {fetch_done, data_done, timeout_err}, 0);
      check("r_address", address, 0);
      check("r_instr", instr, 0);
      chk_z("r_data_z");
      tick();
      check("r_no_late_done", data_done, 0);
      mem_read = 1'b1; mem_address = 16'h0050;
      tick();
      check("r_rd_readM", readM, 1);
      check("r_rd_addr", address, 16'h0050);
      respond_rd(16'h7777);
      tick();
      release_rd();
      mem_read = 1'b0;
      check("r_rd_done", data_done, 1);
      check("r_rd_rdata", rdata, 16'h7777);
      tick();

      // spurious inputReady in IDLE, spurious ackOutput in RD_WAIT
      respond_rd(16'hAAAA);
      tick();
      release_rd();
      check("sp_idle_busy", busy, 0);
      check("sp_idle_pulses", {fetch_done, data_done, timeout_err}, 0);
      check("sp_idle_rdata", rdata, 16'h7777);
      mem_read = 1'b1; mem_address = 16'h0060;
      tick();
      ackOutput = 1'b1;
      tick();
      ackOutput = 1'b0;
      check("sp_ack_readM", readM, 1);
      check("sp_ack_pulses", {fetch_done, data_done, timeout_err}, 0);
      check("sp_ack_writeM", writeM, 0);
      respond_rd(16'h1111);
      tick();
      release_rd();
      mem_read = 1'b0;
      check("sp_rd_done", data_done, 1);
      check("sp_rd_rdata", rdata, 16'h1111);
      tick();
      check("sp_final_idle", busy, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
